// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10,
        FLT_PARITY   = 2'b11
    } fault_e;

    localparam int RSP_DEPTH = 2;

    function automatic int word_ofs_w(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response buffer holding {data, fault}; head is presented combinationally
// from the storage registers, so the outputs hold while the consumer stalls.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  fault_e        push_fault_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output fault_e        fault_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] data_q  [RSP_DEPTH];
    fault_e        fault_q [RSP_DEPTH];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic          push_en;
    logic          pop_en;

    assign pop_en  = pop_i && (count_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_en = push_i && ((count_q != 2'(RSP_DEPTH)) || pop_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                data_q[i]  <= '0;
                fault_q[i] <= FLT_OK;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_en) begin
                data_q[wr_ptr_q]  <= push_data_i;
                fault_q[wr_ptr_q] <= push_fault_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_en) - 2'(pop_en);
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = data_q[rd_ptr_q];
    assign fault_o = fault_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Byte-lane instruction memory with a valid/ready fetch port and a byte-enabled load port.
// Optional per-byte parity storage and checking is enabled with IMEM_PARITY_EN.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WORD_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid_i,
    output logic                  fetch_ready_o,
    input  logic [ADDR_W-1:0]     fetch_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [8*WORD_BYTES-1:0] rsp_data_o,
    output fault_e                rsp_fault_o,
    input  logic                  load_valid_i,
    input  logic [ADDR_W-1:0]     load_addr_i,
    input  logic [8*WORD_BYTES-1:0] load_data_i,
    input  logic [WORD_BYTES-1:0] load_be_i,
    input  logic                  par_inj_i,
    output logic                  load_err_o
);

    localparam int DW      = 8 * WORD_BYTES;
    localparam int OFS_W   = word_ofs_w(WORD_BYTES);
    localparam int ENTRIES = DEPTH_BYTES / WORD_BYTES;
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    function automatic fault_e classify(input logic [ADDR_W-1:0] a);
        if (a[OFS_W-1:0] != '0) return FLT_MISALIGN;
        if (64'(a) >= 64'(DEPTH_BYTES)) return FLT_RANGE;
        return FLT_OK;
    endfunction

    logic          inflight_q, inflight_d;
    fault_e        inflight_fault_q, inflight_fault_d;
    logic          load_err_q, load_err_d;
    logic [1:0]    fifo_count;
    logic [2:0]    occupancy;
    logic          rsp_pop;
    logic          fetch_acc;
    fault_e        req_fault;
    fault_e        ld_fault;
    logic          ld_we;
    logic          rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] ld_idx;
    logic [DW-1:0] rd_data;
    logic          par_err;
    logic          push;
    fault_e        push_fault;
    logic [DW-1:0] push_data;

    assign rsp_pop   = rsp_valid_o && rsp_ready_i;
    // Count the in-flight read so a slot is always reserved for it.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(rsp_pop);
    assign fetch_ready_o = !load_valid_i && (occupancy < 3'(RSP_DEPTH));
    assign fetch_acc = fetch_valid_i && fetch_ready_o;

    assign req_fault = classify(fetch_addr_i);
    assign ld_fault  = classify(load_addr_i);
    assign rd_en     = fetch_acc && (req_fault == FLT_OK);
    assign ld_we     = load_valid_i && (|load_be_i) && (ld_fault == FLT_OK);
    assign rd_idx    = fetch_addr_i[OFS_W +: IDX_W];
    assign ld_idx    = load_addr_i[OFS_W +: IDX_W];

    assign inflight_d       = fetch_acc;
    assign inflight_fault_d = req_fault;
    assign load_err_d       = load_valid_i && (|load_be_i) && (ld_fault != FLT_OK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q       <= 1'b0;
            inflight_fault_q <= FLT_OK;
            load_err_q       <= 1'b0;
        end else begin
            inflight_q       <= inflight_d;
            inflight_fault_q <= inflight_fault_d;
            load_err_q       <= load_err_d;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [WORD_BYTES-1:0] par_mismatch;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] mem [ENTRIES];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clk) begin
                if (ld_we && load_be_i[gi]) begin
                    mem[ld_idx] <= load_data_i[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_byte_q <= mem[rd_idx];
                end
            end
            assign rd_data[8*gi +: 8] = rd_byte_q;

`ifdef IMEM_PARITY_EN
            logic par_mem [ENTRIES];
            logic rd_par_q;

            always_ff @(posedge clk) begin
                if (ld_we && load_be_i[gi]) begin
                    par_mem[ld_idx] <= (^load_data_i[8*gi +: 8]) ^ par_inj_i;
                end
                if (rd_en) begin
                    rd_par_q <= par_mem[rd_idx];
                end
            end
            assign par_mismatch[gi] = (^rd_byte_q) ^ rd_par_q;
`endif
        end
    endgenerate

`ifdef IMEM_PARITY_EN
    assign par_err = |par_mismatch;
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj_i;
    assign par_err        = 1'b0;
`endif

    // Address faults take precedence over parity; any fault zeroes the data.
    assign push       = inflight_q;
    assign push_fault = (inflight_fault_q != FLT_OK) ? inflight_fault_q :
                        (par_err ? FLT_PARITY : FLT_OK);
    assign push_data  = (push_fault == FLT_OK) ? rd_data : '0;

    imem_rsp_fifo #(.DW(DW)) u_rsp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_data_i  (push_data),
        .push_fault_i (push_fault),
        .pop_i        (rsp_pop),
        .valid_o      (rsp_valid_o),
        .data_o       (rsp_data_o),
        .fault_o      (rsp_fault_o),
        .count_o      (fifo_count)
    );

    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: stimulus pushes expected responses, a negedge
// monitor pops and compares each accepted response. Parity cases run under IMEM_PARITY_EN.
module tb_imem_fetch_port;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    fault_e      rsp_fault_o;
    logic        load_valid_i;
    logic [31:0] load_addr_i;
    logic [31:0] load_data_i;
    logic [3:0]  load_be_i;
    logic        par_inj_i;
    logic        load_err_o;

    always #5 clk = ~clk;

    imem_fetch_port #(.ADDR_W(32), .DEPTH_BYTES(1024), .WORD_BYTES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_addr_i  (fetch_addr_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_fault_o   (rsp_fault_o),
        .load_valid_i  (load_valid_i),
        .load_addr_i   (load_addr_i),
        .load_data_i   (load_data_i),
        .load_be_i     (load_be_i),
        .par_inj_i     (par_inj_i),
        .load_err_o    (load_err_o)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  f;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] a4 [3] = '{32'h100, 32'h104, 32'h100};
    logic [31:0] d4 [3] = '{32'hDEADBEEF, 32'h00220044, 32'hDEADBEEF};
    int          n4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got data 0x%08h fault %0d, expected none",
                         rsp_data_o, rsp_fault_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", rsp_data_o, mon_e.d);
                chk("rsp_fault", 32'(rsp_fault_o), 32'(mon_e.f));
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic inj);
        load_valid_i = 1'b1;
        load_addr_i  = a;
        load_data_i  = d;
        load_be_i    = be;
        par_inj_i    = inj;
        @(posedge clk);
        #1;
        load_valid_i = 1'b0;
        load_be_i    = 4'b0;
        par_inj_i    = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f);
        bit ok = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_addr_i  = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (fetch_ready_o) begin
                ok = 1'b1;
                exp_q.push_back({d, f});
            end
            @(posedge clk);
            #1;
        end
        fetch_valid_i = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: addr 0x%08h never accepted, required accept", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_addr_i = '0;
        rsp_ready_i = 1'b1;
        load_valid_i = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;
        load_be_i = '0;
        par_inj_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rsp_data", rsp_data_o, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault_o), 32'd0);
        chk("reset_load_err", 32'(load_err_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full-word load and fetch with one-cycle latency
        do_load(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0);
        do_load(32'h104, 32'h0, 4'b1111, 1'b0);
        do_fetch(32'h100, 32'hDEADBEEF, 2'b00);
        chk("t1_lat_accept_edge", 32'(rsp_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_lat_next_edge", 32'(rsp_valid_o), 32'd1);
        drain();

        // 2: partial byte enables
        do_load(32'h104, 32'h11223344, 4'b0101, 1'b0);
        do_fetch(32'h104, 32'h00220044, 2'b00);
        drain();

        // 3: fault codes and dropped loads
        do_fetch(32'h102, 32'h0, 2'b01);
        do_fetch(32'h400, 32'h0, 2'b10);
        do_fetch(32'h402, 32'h0, 2'b01);
        do_load(32'h401, 32'hFFFFFFFF, 4'b1111, 1'b0);
        chk("t3_load_err_pulse", 32'(load_err_o), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_load_err_clear", 32'(load_err_o), 32'd0);
        do_load(32'h101, 32'hFFFFFFFF, 4'b1111, 1'b0);
        chk("t3_misalign_load_err", 32'(load_err_o), 32'd1);
        do_load(32'h100, 32'h0, 4'b0000, 1'b0);
        chk("t3_be0_no_err", 32'(load_err_o), 32'd0);
        do_fetch(32'h100, 32'hDEADBEEF, 2'b00);
        drain();

        // 4: backpressure, two-slot limit, in-order release
        rsp_ready_i = 1'b0;
        n4 = 0;
        fetch_valid_i = 1'b1;
        fetch_addr_i = a4[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fetch_ready_o) begin
                exp_q.push_back({d4[n4], 2'b00});
                n4++;
            end
            @(posedge clk);
            #1;
            if (n4 < 3) fetch_addr_i = a4[n4];
        end
        chk("t4_accepted", 32'(n4), 32'd2);
        chk("t4_ready_low", 32'(fetch_ready_o), 32'd0);
        chk("t4_hold_valid", 32'(rsp_valid_o), 32'd1);
        chk("t4_hold_data", rsp_data_o, 32'hDEADBEEF);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_ready_release", 32'(fetch_ready_o), 32'd1);
        if (fetch_ready_o && n4 < 3) exp_q.push_back({d4[n4], 2'b00});
        chk("t4_pop0_valid", 32'(rsp_valid_o), 32'd1);
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_pop1_valid", 32'(rsp_valid_o), 32'd1);
        drain();

        // 5: load wins over a simultaneous fetch
        load_valid_i = 1'b1;
        load_addr_i = 32'h10C;
        load_data_i = 32'hCAFEF00D;
        load_be_i = 4'b1111;
        fetch_valid_i = 1'b1;
        fetch_addr_i = 32'h10C;
        @(negedge clk);
        chk("t5_fetch_stalled", 32'(fetch_ready_o), 32'd0);
        @(posedge clk);
        #1;
        load_valid_i = 1'b0;
        load_be_i = 4'b0;
        do_fetch(32'h10C, 32'hCAFEF00D, 2'b00);
        drain();

        // 6: reset with one buffered response and one read in flight
        rsp_ready_i = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_addr_i = 32'h100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        chk("t6_pre_reset_valid", 32'(rsp_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", 32'(rsp_valid_o), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_survivor", 32'(rsp_valid_o), 32'd0);
        do_fetch(32'h104, 32'h00220044, 2'b00);
        do_fetch(32'h10C, 32'hCAFEF00D, 2'b00);
        drain();

`ifdef IMEM_PARITY_EN
        do_load(32'h110, 32'h12345678, 4'b1111, 1'b1);
        do_fetch(32'h110, 32'h0, 2'b11);
        do_load(32'h114, 32'h12345678, 4'b1111, 1'b0);
        do_fetch(32'h114, 32'h12345678, 2'b00);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
